// File: rtl/falu_sequencer.sv
// Request sequencer for the combinational float ALU: queues ops, issues one at a time, returns results in order.
// Latency: accept into an empty idle block -> out_valid after ALU_LAT+1 edges; one result per ALU_LAT+1 cycles.
// Backpressure: in_ready drops when the request FIFO is full; a held result (out_ready low) stalls issue.
module falu_sequencer #(
    parameter int DEPTH   = 4,
    parameter int TAGW    = 4,
    parameter int ALU_LAT = 1
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [1:0]               in_opf,
    input  logic [31:0]              in_regb,
    input  logic [31:0]              in_regc,
    input  logic [TAGW-1:0]          in_tag,
    output logic [1:0]               alu_opf,
    output logic [31:0]              alu_regb,
    output logic [31:0]              alu_regc,
    input  logic [31:0]              alu_rega,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [31:0]              out_rega,
    output logic [TAGW-1:0]          out_tag,
    output logic                     out_nan,
    output logic                     out_inf,
    output logic                     out_zero,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int LW = (ALU_LAT > 1) ? $clog2(ALU_LAT) : 1;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_WAIT = 2'd1;
    localparam logic [1:0] S_HOLD = 2'd2;

    typedef struct packed {
        logic [1:0]      opf;
        logic [31:0]     regb;
        logic [31:0]     regc;
        logic [TAGW-1:0] tag;
    } req_t;

    req_t            r_mem [DEPTH];
    logic [AW-1:0]   r_wr_ptr;
    logic [AW-1:0]   r_rd_ptr;
    logic [CW-1:0]   r_count;
    logic [1:0]      r_state;
    logic [LW-1:0]   r_lat;
    logic [TAGW-1:0] r_tag;
    logic [1:0]      r_alu_opf;
    logic [31:0]     r_alu_regb;
    logic [31:0]     r_alu_regc;
    logic            r_out_valid;
    logic [31:0]     r_out_rega;
    logic [TAGW-1:0] r_out_tag;
    logic            r_out_nan;
    logic            r_out_inf;
    logic            r_out_zero;

    logic            w_push;
    logic            w_pop;
    logic            w_nonempty;
    req_t            w_head;
    req_t            w_in_req;
    logic [7:0]      w_exp;
    logic [22:0]     w_man;
    logic            w_nan;
    logic            w_inf;
    logic            w_zero;

    // Handshake, pop decision and class decode of the live ALU result
    always_comb begin
        w_nonempty = (r_count != '0);
        w_push     = in_valid && in_ready;
        w_pop      = w_nonempty &&
                     ((r_state == S_IDLE) || ((r_state == S_HOLD) && out_ready));
        w_head     = r_mem[r_rd_ptr];
        w_in_req   = '{opf: in_opf, regb: in_regb, regc: in_regc, tag: in_tag};
        w_exp      = alu_rega[30:23];
        w_man      = alu_rega[22:0];
        w_nan      = (w_exp == 8'hFF) && (w_man != '0);
        w_inf      = (w_exp == 8'hFF) && (w_man == '0);
        w_zero     = (w_exp == 8'h00) && (w_man == '0);
    end

    // FIFO storage; entries need no reset because the pointers define validity
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= w_in_req;
        end
    end

    // FIFO pointers and occupancy; power-of-two depth lets pointers wrap naturally
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            if (w_push && !w_pop) begin
                r_count <= r_count + 1'b1;
            end else if (!w_push && w_pop) begin
                r_count <= r_count - 1'b1;
            end
        end
    end

    // Issue/wait/hold sequencer: one op in flight, result held until consumed
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_lat       <= '0;
            r_tag       <= '0;
            r_alu_opf   <= '0;
            r_alu_regb  <= '0;
            r_alu_regc  <= '0;
            r_out_valid <= 1'b0;
            r_out_rega  <= '0;
            r_out_tag   <= '0;
            r_out_nan   <= 1'b0;
            r_out_inf   <= 1'b0;
            r_out_zero  <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_pop) begin
                        r_alu_opf  <= w_head.opf;
                        r_alu_regb <= w_head.regb;
                        r_alu_regc <= w_head.regc;
                        r_tag      <= w_head.tag;
                        r_lat      <= LW'(ALU_LAT - 1);
                        r_state    <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (r_lat == '0) begin
                        r_out_rega  <= alu_rega;
                        r_out_tag   <= r_tag;
                        r_out_nan   <= w_nan;
                        r_out_inf   <= w_inf;
                        r_out_zero  <= w_zero;
                        r_out_valid <= 1'b1;
                        r_state     <= S_HOLD;
                    end else begin
                        r_lat <= r_lat - 1'b1;
                    end
                end
                S_HOLD: begin
                    if (out_ready) begin
                        r_out_valid <= 1'b0;
                        if (w_pop) begin
                            r_alu_opf  <= w_head.opf;
                            r_alu_regb <= w_head.regb;
                            r_alu_regc <= w_head.regc;
                            r_tag      <= w_head.tag;
                            r_lat      <= LW'(ALU_LAT - 1);
                            r_state    <= S_WAIT;
                        end else begin
                            r_state <= S_IDLE;
                        end
                    end
                end
                default: begin
                    r_state     <= S_IDLE;
                    r_out_valid <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready  = (r_count < CW'(DEPTH));
    assign count     = r_count;
    assign alu_opf   = r_alu_opf;
    assign alu_regb  = r_alu_regb;
    assign alu_regc  = r_alu_regc;
    assign out_valid = r_out_valid;
    assign out_rega  = r_out_rega;
    assign out_tag   = r_out_tag;
    assign out_nan   = r_out_nan;
    assign out_inf   = r_out_inf;
    assign out_zero  = r_out_zero;

endmodule

// File: tb/tb_falu_sequencer.sv
// Bench for falu_sequencer: mock falu from a table of hand-computed IEEE-754 results.
// Stimulus pushes expected results into a queue; a negedge monitor pops and compares on each handshake.
// Directed tests: latency, backpressure/full, streaming throughput, class flags, push+pop, mid-op reset.
module tb_falu_sequencer;

    localparam int DEPTH   = 4;
    localparam int TAGW    = 4;
    localparam int ALU_LAT = 1;
    localparam int NV      = 14;

    logic              clk;
    logic              reset;
    logic              in_valid;
    logic              in_ready;
    logic [1:0]        in_opf;
    logic [31:0]       in_regb;
    logic [31:0]       in_regc;
    logic [TAGW-1:0]   in_tag;
    logic [1:0]        alu_opf;
    logic [31:0]       alu_regb;
    logic [31:0]       alu_regc;
    logic [31:0]       alu_rega;
    logic              out_valid;
    logic              out_ready;
    logic [31:0]       out_rega;
    logic [TAGW-1:0]   out_tag;
    logic              out_nan;
    logic              out_inf;
    logic              out_zero;
    logic [$clog2(DEPTH):0] count;

    falu_sequencer #(.DEPTH(DEPTH), .TAGW(TAGW), .ALU_LAT(ALU_LAT)) dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_opf(in_opf), .in_regb(in_regb), .in_regc(in_regc), .in_tag(in_tag),
        .alu_opf(alu_opf), .alu_regb(alu_regb), .alu_regc(alu_regc), .alu_rega(alu_rega),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_rega(out_rega), .out_tag(out_tag),
        .out_nan(out_nan), .out_inf(out_inf), .out_zero(out_zero),
        .count(count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]  opf;
        logic [31:0] b;
        logic [31:0] c;
        logic [31:0] r;
        logic        nan;
        logic        inf;
        logic        zero;
    } vec_t;

    typedef struct {
        logic [31:0]     r;
        logic [TAGW-1:0] tag;
        logic [2:0]      flags;
        logic [1:0]      opf;
        logic [31:0]     b;
        logic [31:0]     c;
    } exp_t;

    vec_t vt [NV];
    exp_t exp_q [$];
    exp_t mon_e;
    int   hs_cyc [$];
    int   cyc = 0;
    int   n_cmp = 0;
    int   n_err = 0;

    // Hand-computed vectors: opf, b, c, result, nan, inf, zero
    initial begin
        vt[0]  = '{2'b00, 32'h3F800000, 32'h40000000, 32'h40400000, 1'b0, 1'b0, 1'b0}; // 1+2=3
        vt[1]  = '{2'b10, 32'h3F800000, 32'h3F800000, 32'h3F800000, 1'b0, 1'b0, 1'b0}; // 1*1=1
        vt[2]  = '{2'b10, 32'h40000000, 32'h40000000, 32'h40800000, 1'b0, 1'b0, 1'b0}; // 2*2=4
        vt[3]  = '{2'b10, 32'h40000000, 32'h40400000, 32'h40C00000, 1'b0, 1'b0, 1'b0}; // 2*3=6
        vt[4]  = '{2'b10, 32'h3F000000, 32'h40800000, 32'h40000000, 1'b0, 1'b0, 1'b0}; // 0.5*4=2
        vt[5]  = '{2'b10, 32'h40400000, 32'h40400000, 32'h41100000, 1'b0, 1'b0, 1'b0}; // 3*3=9
        vt[6]  = '{2'b10, 32'hBF800000, 32'h40000000, 32'hC0000000, 1'b0, 1'b0, 1'b0}; // -1*2=-2
        vt[7]  = '{2'b10, 32'h3FC00000, 32'h40000000, 32'h40400000, 1'b0, 1'b0, 1'b0}; // 1.5*2=3
        vt[8]  = '{2'b10, 32'h40800000, 32'h40800000, 32'h41800000, 1'b0, 1'b0, 1'b0}; // 4*4=16
        vt[9]  = '{2'b10, 32'h7F800000, 32'h3F800000, 32'h7F800000, 1'b0, 1'b1, 1'b0}; // inf*1=inf
        vt[10] = '{2'b00, 32'h7FC00000, 32'h3F800000, 32'h7FC00000, 1'b1, 1'b0, 1'b0}; // nan+1=nan
        vt[11] = '{2'b01, 32'h3F800000, 32'h3F800000, 32'h00000000, 1'b0, 1'b0, 1'b1}; // 1-1=+0
        vt[12] = '{2'b11, 32'h40C00000, 32'h40000000, 32'h40400000, 1'b0, 1'b0, 1'b0}; // 6/2=3
        vt[13] = '{2'b10, 32'h80000000, 32'h3F800000, 32'h80000000, 1'b0, 1'b0, 1'b1}; // -0*1=-0
    end

    // Mock combinational falu: table lookup on the issued operands
    always_comb begin
        alu_rega = 32'hDEADBEEF;
        for (int i = 0; i < NV; i++) begin
            if (vt[i].opf == alu_opf && vt[i].b == alu_regb && vt[i].c == alu_regc) begin
                alu_rega = vt[i].r;
            end
        end
    end

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        n_cmp++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at cycle %0d", name, act, req, cyc);
        end
    endtask

    // Scoreboard monitor: compare on every result handshake
    always @(negedge clk) begin
        if (!reset && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL unexpected_result: got tag %0h rega %0h with no result outstanding", out_tag, out_rega);
            end else begin
                mon_e = exp_q.pop_front();
                chk("out_rega", out_rega, mon_e.r);
                chk("out_tag", out_tag, mon_e.tag);
                chk("flags{nan,inf,zero}", {out_nan, out_inf, out_zero}, mon_e.flags);
                chk("alu_held{opf,b,c}", {alu_opf, alu_regb, alu_regc}, {mon_e.opf, mon_e.b, mon_e.c});
                hs_cyc.push_back(cyc);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Drive one request; expected result is queued only when the request is accepted
    task automatic push(input int vi, input logic [TAGW-1:0] tag);
        in_valid = 1'b1;
        in_opf   = vt[vi].opf;
        in_regb  = vt[vi].b;
        in_regc  = vt[vi].c;
        in_tag   = tag;
        for (int k = 0; k < 200; k++) begin
            @(negedge clk);
            if (in_ready) begin
                exp_q.push_back('{vt[vi].r, tag, {vt[vi].nan, vt[vi].inf, vt[vi].zero},
                                  vt[vi].opf, vt[vi].b, vt[vi].c});
                @(posedge clk);
                #1;
                in_valid = 1'b0;
                return;
            end
        end
        n_cmp++;
        n_err++;
        $display("FAIL push_timeout: in_ready stayed 0 for tag %0h", tag);
        in_valid = 1'b0;
    endtask

    task automatic drain();
        out_ready = 1'b1;
        for (int k = 0; k < 300; k++) begin
            if (exp_q.size() == 0) break;
            step();
        end
        n_cmp++;
        if (exp_q.size() != 0) begin
            n_err++;
            $display("FAIL drain_timeout: %0d results outstanding, required 0", exp_q.size());
        end
        step();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        int n0;
        reset     = 1'b1;
        in_valid  = 1'b0;
        in_opf    = '0;
        in_regb   = '0;
        in_regc   = '0;
        in_tag    = '0;
        out_ready = 1'b0;
        #1;
        chk("reset_out_valid", out_valid, 0);
        chk("reset_count", count, 0);
        chk("reset_alu_regb", alu_regb, 0);
        chk("reset_out_rega", out_rega, 0);
        step();
        step();
        reset = 1'b0;
        step();
        chk("post_reset_in_ready", in_ready, 1);

        // Test 1: single ADD, latency ALU_LAT+1 edges from accept
        push(0, 4'd3);
        chk("lat_edge1_out_valid", out_valid, 0);
        step();
        chk("lat_edge1_out_valid", out_valid, 0);
        step();
        chk("lat_edge2_out_valid", out_valid, 1);
        drain();

        // Test 2: fill with out_ready low; sixth request refused
        out_ready = 1'b0;
        for (int t = 0; t < 5; t++) push(0, TAGW'(t));
        chk("full_count", count, DEPTH);
        chk("full_in_ready", in_ready, 0);
        in_valid = 1'b1;
        in_tag   = 4'd5;
        for (int k = 0; k < 3; k++) begin
            step();
            chk("full_hold_in_ready", in_ready, 0);
        end
        chk("full_hold_count", count, DEPTH);
        in_valid = 1'b0;
        drain();

        // Test 3: stream 8 MULs with out_ready high
        out_ready = 1'b1;
        n0 = hs_cyc.size();
        for (int i = 1; i <= 8; i++) push(i, TAGW'(i));
        drain();
        chk("stream_results", hs_cyc.size() - n0, 8);
        for (int i = 1; i < 8; i++) begin
            chk("stream_spacing", hs_cyc[n0 + i] - hs_cyc[n0 + i - 1], ALU_LAT + 1);
        end

        // Test 4: class flags
        for (int i = 9; i <= 13; i++) push(i, TAGW'(i));
        drain();

        // Test 5: simultaneous push and pop keeps occupancy
        out_ready = 1'b0;
        for (int t = 8; t < 13; t++) push(t - 4, TAGW'(t));
        chk("pp_full_count", count, DEPTH);
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        chk("pp_after_pop_count", count, DEPTH - 1);
        step();
        out_ready = 1'b1;
        push(12, 4'd13);
        out_ready = 1'b0;
        chk("pp_same_edge_count", count, DEPTH - 1);
        drain();

        // Test 6: reset while WAIT with 3 queued
        out_ready = 1'b0;
        for (int t = 1; t < 5; t++) push(t, TAGW'(t));
        out_ready = 1'b1;
        push(5, 4'd5);
        out_ready = 1'b0;
        chk("prereset_count", count, 3);
        #2;
        reset = 1'b1;
        #1;
        exp_q.delete();
        chk("midreset_out_valid", out_valid, 0);
        chk("midreset_count", count, 0);
        chk("midreset_in_ready", in_ready, 1);
        step();
        step();
        reset = 1'b0;
        step();
        step();
        chk("postreset_out_valid", out_valid, 0);
        chk("postreset_in_ready", in_ready, 1);
        push(12, 4'd7);
        drain();

        chk("scoreboard_empty", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
